// File: rtl/apb_master_ctrl.sv
// APB master controller: turns a valid/ready command into one APB transfer
// (SETUP then ACCESS) and returns a single-cycle response strobe.
module apb_master_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       txn_count,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e     state;
  logic [7:0] wait_cnt;
  logic       timeout_hit;

  // True in the ACCESS cycle whose pready=0 edge would bring the counter to TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && (({1'b0, wait_cnt} + 9'd1) == TIMEOUT[8:0]);

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state     <= StIdle;
      cmd_ready <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      txn_count <= '0;
      wait_cnt  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        StIdle: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            state     <= StSetup;
            cmd_ready <= 1'b0;
            psel      <= 1'b1;
            pwrite    <= cmd_write;
            paddr     <= cmd_addr;
            pwdata    <= cmd_wdata;
          end
        end
        StSetup: begin
          state    <= StAccess;
          penable  <= 1'b1;
          wait_cnt <= '0;
        end
        StAccess: begin
          // pready is tested first so it wins over a coincident timeout.
          if (pready) begin
            state     <= StIdle;
            cmd_ready <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= (!pwrite && !pslverr) ? prdata : 32'h0;
            txn_count <= txn_count + 16'd1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (timeout_hit) begin
              state     <= StIdle;
              cmd_ready <= 1'b1;
              psel      <= 1'b0;
              penable   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
              txn_count <= txn_count + 16'd1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: a TIMEOUT=16 instance and a TIMEOUT=0
// instance share stimulus; outputs are sampled 1 time unit after each rising edge.
module tb_apb_master_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_reset;
  logic        cmd_valid, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata, prdata;
  logic        pready, pslverr;

  logic        cmd_ready_0, rsp_valid_0, rsp_err_0, psel_0, penable_0, pwrite_0;
  logic [31:0] rsp_rdata_0, pwdata_0;
  logic [15:0] txn_count_0;
  logic [7:0]  paddr_0;

  logic        cmd_ready_1, rsp_valid_1, rsp_err_1, psel_1, penable_1, pwrite_1;
  logic [31:0] rsp_rdata_1, pwdata_1;
  logic [15:0] txn_count_1;
  logic [7:0]  paddr_1;

  int vectors = 0;
  int miscompares = 0;
  int n;
  int k;
  int setup_cyc [4];

  always #5 sys_clk = ~sys_clk;

  apb_master_ctrl #(.ADDR_W(8), .TIMEOUT(16)) dut0 (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_0), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_0), .rsp_rdata(rsp_rdata_0), .rsp_err(rsp_err_0),
    .txn_count(txn_count_0),
    .psel(psel_0), .penable(penable_0), .pwrite(pwrite_0), .paddr(paddr_0),
    .pwdata(pwdata_0), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_master_ctrl #(.ADDR_W(8), .TIMEOUT(0)) dut1 (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_1), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_1), .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_1),
    .txn_count(txn_count_1),
    .psel(psel_1), .penable(penable_1), .pwrite(pwrite_1), .paddr(paddr_1),
    .pwdata(pwdata_1), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    sys_reset = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;

    // Reset state
    #2;
    chk("rst_cmd_ready", {31'b0, cmd_ready_0}, 32'h0);
    chk("rst_psel", {31'b0, psel_0}, 32'h0);
    chk("rst_txn", {16'b0, txn_count_0}, 32'h0);
    chk("rst_paddr", {24'b0, paddr_0}, 32'h0);
    step();
    sys_reset = 1'b1;
    chk("rel_cmd_ready_low", {31'b0, cmd_ready_0}, 32'h0);
    step();
    chk("rel_cmd_ready_high", {31'b0, cmd_ready_0}, 32'h1);

    // Write, zero wait
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h04; cmd_wdata = 32'hA5A5_0001;
    pready = 1'b1;
    step();
    cmd_valid = 1'b0; cmd_wdata = 32'h1111_2222;
    chk("wr_setup_psel", {30'b0, psel_0, penable_0}, 32'h2);
    chk("wr_setup_ready", {31'b0, cmd_ready_0}, 32'h0);
    chk("wr_paddr", {24'b0, paddr_0}, 32'h04);
    chk("wr_pwrite", {31'b0, pwrite_0}, 32'h1);
    step();
    chk("wr_access_psel", {30'b0, psel_0, penable_0}, 32'h3);
    chk("wr_pwdata", pwdata_0, 32'hA5A5_0001);
    step();
    chk("wr_rsp_valid", {31'b0, rsp_valid_0}, 32'h1);
    chk("wr_rsp_err", {31'b0, rsp_err_0}, 32'h0);
    chk("wr_rsp_rdata", rsp_rdata_0, 32'h0);
    chk("wr_txn", {16'b0, txn_count_0}, 32'h1);
    chk("wr_idle_psel", {30'b0, psel_0, penable_0}, 32'h0);
    chk("wr_idle_ready", {31'b0, cmd_ready_0}, 32'h1);
    chk("wr_pwdata_hold", pwdata_0, 32'hA5A5_0001);
    step();
    chk("wr_rsp_pulse", {31'b0, rsp_valid_0}, 32'h0);

    // Read, 3 wait states
    pready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h08;
    step();
    cmd_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!penable_0) break;
      n++;
      if (n == 4) begin
        pready = 1'b1;
        prdata = 32'h0000_1234;
      end
    end
    chk("rd_penable_cycles", n, 32'd4);
    chk("rd_rsp_valid", {31'b0, rsp_valid_0}, 32'h1);
    chk("rd_rsp_rdata", rsp_rdata_0, 32'h0000_1234);
    chk("rd_rsp_err", {31'b0, rsp_err_0}, 32'h0);
    chk("rd_txn", {16'b0, txn_count_0}, 32'h2);

    // Slave error on a read
    prdata = 32'hDEAD_BEEF; pslverr = 1'b1; pready = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 8'h10;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("err_rsp_valid", {31'b0, rsp_valid_0}, 32'h1);
    chk("err_rsp_err", {31'b0, rsp_err_0}, 32'h1);
    chk("err_rsp_rdata", rsp_rdata_0, 32'h0);
    chk("err_txn", {16'b0, txn_count_0}, 32'h3);
    pslverr = 1'b0;
    step();
    chk("err_hold_valid", {31'b0, rsp_valid_0}, 32'h0);
    chk("err_hold_err", {31'b0, rsp_err_0}, 32'h1);

    // Timeout: dut0 gives up after 16 ACCESS cycles, dut1 waits forever
    pready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 8'h20;
    step();
    cmd_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!psel_0) break;
      n++;
    end
    chk("to_access_cycles", n, 32'd16);
    chk("to_rsp_valid", {31'b0, rsp_valid_0}, 32'h1);
    chk("to_rsp_err", {31'b0, rsp_err_0}, 32'h1);
    chk("to_rsp_rdata", rsp_rdata_0, 32'h0);
    chk("to_txn", {16'b0, txn_count_0}, 32'h4);
    repeat (20) step();
    chk("to0_psel_held", {30'b0, psel_1, penable_1}, 32'h3);
    chk("to0_no_rsp", {31'b0, rsp_valid_1}, 32'h0);
    prdata = 32'h0000_0055; pready = 1'b1;
    step();
    chk("to0_rsp_valid", {31'b0, rsp_valid_1}, 32'h1);
    chk("to0_rsp_rdata", rsp_rdata_1, 32'h0000_0055);
    chk("to0_rsp_err", {31'b0, rsp_err_1}, 32'h0);
    chk("to0_txn", {16'b0, txn_count_1}, 32'h4);
    pready = 1'b0;
    step();

    // Mid-transfer reset during ACCESS
    cmd_valid = 1'b1; cmd_addr = 8'h40;
    step();
    cmd_valid = 1'b0;
    step();
    chk("mr_in_access", {30'b0, psel_0, penable_0}, 32'h3);
    #2 sys_reset = 1'b0;
    #1;
    chk("mr_psel_async", {30'b0, psel_0, penable_0}, 32'h0);
    chk("mr_ready_async", {31'b0, cmd_ready_0}, 32'h0);
    chk("mr_txn_cleared", {16'b0, txn_count_0}, 32'h0);
    step();
    chk("mr_no_rsp", {31'b0, rsp_valid_0}, 32'h0);
    sys_reset = 1'b1;
    chk("mr_ready_before_edge", {31'b0, cmd_ready_0}, 32'h0);
    step();
    chk("mr_ready_first_edge", {31'b0, cmd_ready_0}, 32'h1);
    chk("mr_idle_psel", {31'b0, psel_0}, 32'h0);

    // Back-to-back: four commands with cmd_valid held
    pready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30; cmd_wdata = 32'h0BAD_F00D;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (psel_0 && !penable_0) begin
        setup_cyc[k] = i;
        k++;
        if (k == 4) begin
          cmd_valid = 1'b0;
          break;
        end
      end
    end
    chk("b2b_setups", k, 32'd4);
    chk("b2b_setup0", setup_cyc[0], 32'd1);
    chk("b2b_setup1", setup_cyc[1], 32'd4);
    chk("b2b_setup2", setup_cyc[2], 32'd7);
    chk("b2b_setup3", setup_cyc[3], 32'd10);
    step();
    step();
    chk("b2b_rsp_valid", {31'b0, rsp_valid_0}, 32'h1);
    chk("b2b_txn", {16'b0, txn_count_0}, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 The block SHALL use one clock, sys_clk; its reset, sys_reset, SHALL be asynchronous and active-low.
REQ-002 Parameter ADDR_W, default 8, SHALL set the APB address width in bits.
REQ-003 Parameter TIMEOUT, default 16, range 0..255, SHALL set the maximum number of PREADY-low ACCESS cycles; 0 disables the timeout.
REQ-004 Ports (name, direction, width, meaning):
- sys_clk  in  1  system clock, rising-edge active
- sys_reset  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  read data, 0 for writes and errors
- rsp_err  out  1  PSLVERR or timeout
- txn_count  out  16  completed-transfer counter
- psel, penable, pwrite  out  1 each  APB control
- paddr  out  ADDR_W  APB address
- pwdata  out  32  APB write data
- prdata  in  32  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

Function
REQ-005 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-006 Transitions SHALL be:
- IDLE->SETUP on cmd_valid&cmd_ready
- SETUP->ACCESS unconditionally
- ACCESS->IDLE on pready=1 or timeout
- otherwise ACCESS holds
REQ-007 cmd_ready SHALL be registered: it is 0 in reset, 1 from the first rising edge after reset release, and thereafter 1 iff state=IDLE.
REQ-008 On acceptance, cmd_write/addr/wdata SHALL be latched into pwrite/paddr/pwdata, which are held stable through SETUP and ACCESS and retain their last values in IDLE.
REQ-009 Outputs by state SHALL be: SETUP, psel=1 and penable=0; ACCESS, psel=1 and penable=1; IDLE, psel=0 and penable=0.
REQ-010 In an ACCESS cycle with pready=1, the block SHALL capture prdata (reads only, else 0) and pslverr, and drive rsp_valid=1 with the captured rsp_rdata/rsp_err for exactly one cycle, in the cycle after the completing edge.
REQ-011 A wait counter (8-bit) SHALL reset to 0 on entering ACCESS and increment each ACCESS cycle with pready=0.
- When TIMEOUT≠0 and the counter reaches TIMEOUT, the transfer SHALL end: return to IDLE with rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-012 Minimum throughput SHALL be one transfer per 3 cycles (SETUP, ACCESS, IDLE); back-to-back commands SHALL never skip the IDLE cycle.
REQ-013 cmd_valid while cmd_ready=0 SHALL be ignored; the requester holds the command until it is accepted.
REQ-014 txn_count SHALL increment by 1 on every rsp_valid, including errors and timeouts, and wrap from 0xFFFF to 0x0000.
REQ-015 rsp_rdata/rsp_err SHALL hold their values between responses; only rsp_valid pulses.
REQ-016 Simultaneous pready=1 and timeout threshold SHALL be treated as normal completion (pready wins).

Reset
REQ-017 Asserting sys_reset SHALL immediately force:
- state=IDLE
- psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err = 0
- paddr, pwdata, rsp_rdata, txn_count = 0
- wait counter = 0
REQ-018 A reset during SETUP or ACCESS SHALL abort the transfer with no response and no txn_count increment.

Verification
REQ-019 Write, zero wait: cmd write addr=0x04 data=0xA5A5_0001 with pready=1 -> SETUP then ACCESS, pwdata stable; rsp_valid 1 cycle, rsp_err=0, txn_count=1.
REQ-020 Read, 3 wait states: addr=0x08, pready low for 3 ACCESS cycles then high with prdata=0x0000_1234 -> penable high for 4 cycles, rsp_rdata=0x1234.
REQ-021 Slave error: read with pslverr=1 at pready -> rsp_err=1, rsp_rdata=0.
REQ-022 Timeout: TIMEOUT=16, pready held 0 -> psel drops after 16 ACCESS cycles, rsp_err=1; with TIMEOUT=0, psel stays high indefinitely.
REQ-023 Back-to-back: cmd_valid held for 4 commands -> psel rises every 3 cycles, txn_count=4.
REQ-024 Mid-transfer reset: sys_reset low during ACCESS -> psel/penable/cmd_ready=0 asynchronously, no rsp_valid; after release, cmd_ready=1 on the first edge.
